// File: rtl/cnn_pkg.sv
// Shared geometry helpers for the CNN output path: line, beat and beat-count sizing.
package cnn_pkg;

    function automatic int unsigned calc_line_w(int unsigned data_width, int unsigned map_size);
        return data_width * (map_size / 2) * (map_size / 2);
    endfunction

    function automatic int unsigned calc_beats(int unsigned map_size, int unsigned out_pix);
        return ((map_size / 2) * (map_size / 2)) / out_pix;
    endfunction

    function automatic int unsigned calc_beat_w(int unsigned out_pix, int unsigned data_width);
        return out_pix * data_width;
    endfunction

    localparam int unsigned LINE_W = calc_line_w(8, 32);
    localparam int unsigned BEATS  = calc_beats(32, 4);
    localparam int unsigned BEAT_W = calc_beat_w(4, 8);

endpackage

// File: rtl/ofm_line_fifo.sv
// Line FIFO for whole output feature-map lines: storage, wrapping pointers, occupancy count.
module ofm_line_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Line storage is deliberately left unreset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ofm_stream_out.sv
// Captures pooled ofm lines into a small FIFO and streams each as fixed-width valid/ready beats.
module ofm_stream_out
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAP_SIZE   = 32,
    parameter int unsigned OUT_PIX    = 4,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        ofm_wr,
    input  logic [ADDR_WIDTH-1:0]                       ofm_addr,
    input  logic [calc_line_w(DATA_WIDTH, MAP_SIZE)-1:0] ofm_writedata,
    output logic                                        ofm_full,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic [OUT_PIX*DATA_WIDTH-1:0]               m_data,
    output logic [ADDR_WIDTH-1:0]                       m_chan,
    output logic                                        m_first,
    output logic                                        m_last,
    output logic                                        overflow,
    input  logic                                        ovf_clr
);

    localparam int unsigned LineW    = calc_line_w(DATA_WIDTH, MAP_SIZE);
    localparam int unsigned NumBeats = calc_beats(MAP_SIZE, OUT_PIX);
    localparam int unsigned BeatW    = calc_beat_w(OUT_PIX, DATA_WIDTH);
    localparam int unsigned BeatCntW = $clog2(NumBeats);
    localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(NumBeats - 1);

    logic [ADDR_WIDTH+LineW-1:0] head;
    logic                        fifo_empty;
    logic                        hs, pop;
    logic [BeatCntW-1:0]         beat_q, beat_d;
    logic                        overflow_q, overflow_d;

    ofm_line_fifo #(
        .WIDTH (ADDR_WIDTH + LineW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ofm_wr),
        .pop   (pop),
        .wdata ({ofm_addr, ofm_writedata}),
        .rdata (head),
        .full  (ofm_full),
        .empty (fifo_empty)
    );

    assign m_valid  = !fifo_empty;
    assign hs       = m_valid && m_ready;
    assign pop      = hs && (beat_q == LastBeat);
    assign m_data   = head[int'(beat_q) * BeatW +: BeatW];
    assign m_chan   = head[LineW +: ADDR_WIDTH];
    assign m_first  = m_valid && (beat_q == '0);
    assign m_last   = m_valid && (beat_q == LastBeat);
    assign overflow = overflow_q;

    always_comb begin
        beat_d     = beat_q;
        overflow_d = overflow_q;
        if (hs) beat_d = pop ? '0 : beat_q + 1'b1;
        // A dropped write wins over a simultaneous clear so no loss goes unreported.
        if (ofm_wr && ofm_full) overflow_d = 1'b1;
        else if (ovf_clr)       overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
